// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared widths, byte-array type and helpers for the capture stream path
package rle_pkg;

   localparam int DW = 32;
   localparam int KW = DW / 8;
   localparam int IW = $clog2(KW);
   localparam int CW = $clog2(KW + 1);
   localparam int TW = $clog2(2 * KW);

   typedef logic [KW-1:0][7:0] byte_arr_t;

   typedef enum logic {
      FL_IDLE    = 1'b0,
      FL_PENDING = 1'b1
   } flush_state_t;

   // Number of byte groups that are enabled (cleared bits in the disable mask).
   function automatic logic [CW-1:0] count_enabled(input logic [KW-1:0] dis);
      logic [CW-1:0] n;
      n = '0;
      for (int g = 0; g < KW; g++) begin
         n = n + {{(CW-1){1'b0}}, ~dis[g]};
      end
      return n;
   endfunction

endpackage

// File: rtl/grp_compact.sv
// rtl/grp_compact.sv - squeezes enabled byte groups of one word down to the low positions
module grp_compact
   import rle_pkg::*;
(
   input  logic [DW-1:0] data,
   input  logic [KW-1:0] disabled_groups,
   output byte_arr_t     comp,
   output logic [CW-1:0] enabled
);

   byte_arr_t     src;
   logic [CW-1:0] pos;

   assign src     = data;
   assign enabled = count_enabled(disabled_groups);

   // Walk the groups in ascending order, dropping each enabled byte into the next free slot.
   always_comb begin
      comp = '0;
      pos  = '0;
      for (int g = 0; g < KW; g++) begin
         if (!disabled_groups[g]) begin
            comp[pos[IW-1:0]] = src[g];
            pos = pos + CW'(1);
         end
      end
   end

endmodule

// File: rtl/grp_pack.sv
// rtl/grp_pack.sv - packs enabled byte groups densely into full output words with flush drain
module grp_pack
   import rle_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [KW-1:0] disabledGroups,
   input  logic          flush,
   output logic          flush_done,
   input  logic [DW-1:0] sti_data,
   input  logic          sti_valid,
   output logic          sti_ready,
   output logic [DW-1:0] sto_data,
   output logic [KW-1:0] sto_keep,
   output logic          sto_valid,
   input  logic          sto_ready
);

   byte_arr_t      comp;
   logic [CW-1:0]  enabled;
   logic [DW-1:0]  acc_q;
   logic [IW-1:0]  fill_q;
   flush_state_t   state_q;
   flush_state_t   state_d;
   logic           out_free;
   logic           accept;
   logic           drain;
   logic [TW-1:0]  total;
   logic           emit;
   logic [2*DW-1:0] merged;
   logic [KW-1:0]  keep_part;

   grp_compact u_compact (
      .data            (sti_data),
      .disabled_groups (disabledGroups),
      .comp            (comp),
      .enabled         (enabled)
   );

   assign out_free  = !sto_valid || sto_ready;
   assign sti_ready = out_free && (state_q == FL_IDLE);
   assign accept    = sti_valid && sti_ready;

   // Bytes above fill in the accumulator are kept zero, so appending is a shift-and-OR.
   assign merged    = {{DW{1'b0}}, acc_q} | ({{DW{1'b0}}, comp} << {fill_q, 3'b000});
   assign total     = TW'(fill_q) + TW'(enabled);
   assign emit      = (total >= TW'(KW));
   assign keep_part = (KW'(1) << fill_q) - KW'(1);

   // Flush state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Flush sequencing: a pending flush drains once the output register can take a word.
   always_comb begin
      state_d = state_q;
      drain   = 1'b0;
      case (state_q)
         FL_IDLE: begin
            if (flush) begin
               state_d = FL_PENDING;
            end
         end
         FL_PENDING: begin
            if (out_free) begin
               drain   = 1'b1;
               state_d = FL_IDLE;
            end
         end
         default: state_d = FL_IDLE;
      endcase
   end

   // Accumulator, output word register and flush completion pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         fill_q     <= '0;
         sto_data   <= '0;
         sto_keep   <= '0;
         sto_valid  <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         flush_done <= drain;
         if (accept) begin
            if (emit) begin
               sto_data  <= merged[DW-1:0];
               sto_keep  <= '1;
               sto_valid <= 1'b1;
               acc_q     <= merged[2*DW-1:DW];
               fill_q    <= IW'(total - TW'(KW));
            end else begin
               acc_q     <= merged[DW-1:0];
               fill_q    <= IW'(total);
               sto_valid <= 1'b0;
            end
         end else if (drain) begin
            if (fill_q != '0) begin
               sto_data  <= acc_q;
               sto_keep  <= keep_part;
               sto_valid <= 1'b1;
               acc_q     <= '0;
               fill_q    <= '0;
            end else begin
               sto_valid <= 1'b0;
            end
         end else if (out_free) begin
            sto_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_grp_pack.sv
// tb/tb_grp_pack.sv - scoreboard bench for grp_pack with directed vectors
module tb_grp_pack;
   import rle_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic [KW-1:0] disabledGroups;
   logic          flush;
   logic          flush_done;
   logic [DW-1:0] sti_data;
   logic          sti_valid;
   logic          sti_ready;
   logic [DW-1:0] sto_data;
   logic [KW-1:0] sto_keep;
   logic          sto_valid;
   logic          sto_ready;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          e;
   int            n_checks = 0;
   int            n_pass = 0;
   int            fd_seen = 0;
   int            fd_exp = 0;
   bit            held = 1'b0;
   logic [DW-1:0] held_data;
   logic [KW-1:0] held_keep;

   always #5 clk = ~clk;

   grp_pack dut (
      .clk            (clk),
      .rst            (rst),
      .disabledGroups (disabledGroups),
      .flush          (flush),
      .flush_done     (flush_done),
      .sti_data       (sti_data),
      .sti_valid      (sti_valid),
      .sti_ready      (sti_ready),
      .sto_data       (sto_data),
      .sto_keep       (sto_keep),
      .sto_valid      (sto_valid),
      .sto_ready      (sto_ready)
   );

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
   endtask

   // Monitor: pops the scoreboard on every output transfer and checks stall stability.
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held) begin
            chk(sto_valid && sto_data == held_data && sto_keep == held_keep, "hold_stable",
                {sto_valid, sto_keep, sto_data}, {1'b1, held_keep, held_data});
         end
         if (flush_done) fd_seen++;
         if (sto_valid && sto_ready) begin
            if (exp_q.size() == 0) begin
               chk(exp_q.size() != 0, "unexpected_word", sto_data, 0);
            end else begin
               e = exp_q.pop_front();
               chk(sto_data == e.data, "word_data", sto_data, e.data);
               chk(sto_keep == e.keep, "word_keep", sto_keep, e.keep);
            end
         end
         held      = sto_valid && !sto_ready;
         held_data = sto_data;
         held_keep = sto_keep;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input bit with_flush);
      int n = 0;
      sti_data  = d;
      sti_valid = 1'b1;
      flush     = with_flush;
      @(negedge clk);
      while (!sti_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk(sti_ready, "send_timeout", sti_ready, 1);
      tick();
      sti_valid = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic wait_flush_done(input string name);
      int n = 0;
      fd_exp++;
      while (fd_seen < fd_exp && n < 50) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk(fd_seen == fd_exp, name, fd_seen, fd_exp);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk(exp_q.size() == 0, name, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst            = 1'b1;
      flush          = 1'b0;
      sti_valid      = 1'b0;
      sti_data       = '0;
      sto_ready      = 1'b1;
      disabledGroups = 4'b1110;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk(sto_valid == 1'b0, "rst_sto_valid", sto_valid, 0);
      chk(sto_data == '0, "rst_sto_data", sto_data, 0);
      chk(sto_keep == '0, "rst_sto_keep", sto_keep, 0);
      chk(flush_done == 1'b0, "rst_flush_done", flush_done, 0);
      chk(sti_ready == 1'b1, "rst_sti_ready", sti_ready, 1);

      // 8-bit mode: four single bytes form one word.
      tick();
      disabledGroups = 4'b1110;
      exp_q.push_back('{32'h44332211, 4'hF});
      send(32'h00000011, 0);
      send(32'h00000022, 0);
      send(32'h00000033, 0);
      chk(sto_valid == 1'b0, "t1_no_early", sto_valid, 0);
      send(32'h00000044, 0);
      chk(sto_valid == 1'b1, "t1_latency", sto_valid, 1);
      drain("t1_drain");

      // 16-bit mode, then a flush with nothing buffered.
      disabledGroups = 4'b1100;
      exp_q.push_back('{32'hDDCCBBAA, 4'hF});
      send(32'h0000BBAA, 0);
      send(32'h0000DDCC, 0);
      drain("t2_drain");
      do_flush();
      wait_flush_done("t2_flush_done");
      drain("t2_no_extra");

      // 24-bit mode, words straddle beats, flush leaves one byte.
      disabledGroups = 4'b1000;
      exp_q.push_back('{32'h44332211, 4'hF});
      exp_q.push_back('{32'h88776655, 4'hF});
      exp_q.push_back('{32'h00000099, 4'b0001});
      send(32'h00332211, 0);
      send(32'h00665544, 0);
      send(32'h00998877, 0);
      do_flush();
      wait_flush_done("t3_flush_done");
      drain("t3_drain");

      // 32-bit mode with a five-cycle downstream stall.
      disabledGroups = 4'b0000;
      for (int i = 0; i < 4; i++) exp_q.push_back('{DW'(i), 4'hF});
      sto_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send(DW'(i), 0);
         end
         begin
            int n = 0;
            while (!sto_valid && n < 50) begin
               tick();
               n++;
            end
            chk(sto_valid == 1'b1, "t4_first_out", sto_valid, 1);
            repeat (5) begin
               @(negedge clk);
               chk(sti_ready == 1'b0, "t4_stall_ready", sti_ready, 0);
            end
            tick();
            sto_ready = 1'b1;
         end
      join
      drain("t4_drain");

      // Flush coinciding with an accepted beat.
      disabledGroups = 4'b1110;
      exp_q.push_back('{32'h00AABB00, 4'b0111});
      send(32'h00000000, 0);
      send(32'h000000BB, 0);
      send(32'h000000AA, 1);
      wait_flush_done("t5_flush_done");
      drain("t5_drain");

      // Reset with bytes buffered and an unconsumed output word.
      disabledGroups = 4'b0100;
      sto_ready = 1'b0;
      send(32'h44332211, 0);
      send(32'h88776655, 0);
      @(negedge clk);
      chk(sto_valid == 1'b1, "t6_pre_valid", sto_valid, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk(sto_valid == 1'b0, "t6_rst_valid", sto_valid, 0);
      chk(sto_keep == '0, "t6_rst_keep", sto_keep, 0);
      chk(sto_data == '0, "t6_rst_data", sto_data, 0);
      chk(sti_ready == 1'b1, "t6_rst_ready", sti_ready, 1);
      tick();
      sto_ready = 1'b1;
      disabledGroups = 4'b1110;
      exp_q.push_back('{32'hDDCCBBAA, 4'hF});
      send(32'h000000AA, 0);
      send(32'h000000BB, 0);
      send(32'h000000CC, 0);
      send(32'h000000DD, 0);
      drain("t6_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
